// File: rtl/cv32e40p_rf_ecc_scrubber.sv
// Background scrubber for the Hamming-protected register file.
// Periodically borrows the RF port, reads one codeword, hands it to the
// external checker, writes corrected data back on a single-bit error and
// logs/flags a double-bit error. Losing the grant mid-pass discards the pass.
module cv32e40p_rf_ecc_scrubber #(
   parameter int NUM_WORDS  = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int FIRST_ADDR = 1,
   parameter int INTERVAL   = 1024,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable_i,
   input  logic                  clear_i,
   output logic                  scrub_req_o,
   input  logic                  scrub_gnt_i,
   output logic [ADDR_WIDTH-1:0] raddr_o,
   input  logic [37:0]           rdata_i,
   output logic [37:0]           chk_codeword_o,
   input  logic [31:0]           chk_data_i,
   input  logic                  chk_single_err_i,
   input  logic                  chk_double_err_i,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] waddr_o,
   output logic [31:0]           wdata_o,
   output logic [CNT_WIDTH-1:0]  sec_count_o,
   output logic [CNT_WIDTH-1:0]  ded_count_o,
   output logic [ADDR_WIDTH-1:0] ded_addr_o,
   output logic                  ded_irq_o,
   output logic                  sweep_done_o
);

   localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam logic [IW-1:0]         IVL_LAST   = IW'(INTERVAL - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(FIRST_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_READ, S_CHECK, S_WRITE, S_NEXT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q;
   logic [IW-1:0]         ivl_cnt_q;
   logic [37:0]           cw_q;
   logic [31:0]           wdata_q;
   logic [CNT_WIDTH-1:0]  sec_cnt_q, ded_cnt_q;
   logic [ADDR_WIDTH-1:0] ded_addr_q;
   logic                  ded_irq_q;

   // Checker results only count when the pass still owns the port.
   logic sec_evt, ded_evt;
   assign ded_evt = (state_q == S_CHECK) && scrub_gnt_i && chk_double_err_i;
   assign sec_evt = (state_q == S_CHECK) && scrub_gnt_i && chk_single_err_i && !chk_double_err_i;

   // Next-state and combinational outputs; outputs are idle-zero by default.
   always_comb begin
      state_d        = state_q;
      scrub_req_o    = 1'b0;
      raddr_o        = '0;
      chk_codeword_o = '0;
      we_o           = 1'b0;
      waddr_o        = '0;
      wdata_o        = '0;
      sweep_done_o   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable_i && ivl_cnt_q == IVL_LAST) state_d = S_REQ;
         end
         S_REQ: begin
            scrub_req_o = 1'b1;
            raddr_o     = cur_addr_q;
            if (scrub_gnt_i) state_d = S_READ;
         end
         S_READ: begin
            scrub_req_o = 1'b1;
            raddr_o     = cur_addr_q;
            state_d     = scrub_gnt_i ? S_CHECK : S_REQ;
         end
         S_CHECK: begin
            scrub_req_o    = 1'b1;
            chk_codeword_o = cw_q;
            if (!scrub_gnt_i)          state_d = S_REQ;
            else if (chk_double_err_i) state_d = S_NEXT;
            else if (chk_single_err_i) state_d = S_WRITE;
            else                       state_d = S_NEXT;
         end
         S_WRITE: begin
            scrub_req_o = 1'b1;
            we_o        = scrub_gnt_i;
            waddr_o     = cur_addr_q;
            wdata_o     = wdata_q;
            state_d     = scrub_gnt_i ? S_NEXT : S_REQ;
         end
         S_NEXT: begin
            sweep_done_o = (cur_addr_q == ADDR_LAST);
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, address walk, interval timer and captured codeword/data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cur_addr_q <= ADDR_FIRST;
         ivl_cnt_q  <= '0;
         cw_q       <= '0;
         wdata_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && enable_i)
            ivl_cnt_q <= (ivl_cnt_q == IVL_LAST) ? '0 : ivl_cnt_q + 1'b1;
         if (state_q == S_READ && scrub_gnt_i)
            cw_q <= rdata_i;
         if (sec_evt)
            wdata_q <= chk_data_i;
         if (state_q == S_NEXT)
            cur_addr_q <= (cur_addr_q == ADDR_LAST) ? ADDR_FIRST : cur_addr_q + 1'b1;
      end
   end

   // Saturating error counters and double-error log; a same-cycle event wins over clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_cnt_q  <= '0;
         ded_cnt_q  <= '0;
         ded_addr_q <= '0;
         ded_irq_q  <= 1'b0;
      end else begin
         if (clear_i)                         sec_cnt_q <= sec_evt ? CNT_WIDTH'(1) : '0;
         else if (sec_evt && ~&sec_cnt_q)     sec_cnt_q <= sec_cnt_q + 1'b1;
         if (clear_i)                         ded_cnt_q <= ded_evt ? CNT_WIDTH'(1) : '0;
         else if (ded_evt && ~&ded_cnt_q)     ded_cnt_q <= ded_cnt_q + 1'b1;
         if (ded_evt) begin
            ded_addr_q <= cur_addr_q;
            ded_irq_q  <= 1'b1;
         end else if (clear_i) begin
            ded_addr_q <= '0;
            ded_irq_q  <= 1'b0;
         end
      end
   end

   assign sec_count_o = sec_cnt_q;
   assign ded_count_o = ded_cnt_q;
   assign ded_addr_o  = ded_addr_q;
   assign ded_irq_o   = ded_irq_q;

endmodule
